stopwatch_core: RTL and testbench
=================================

// Module: stopwatch_core
// PURPOSE
//   Tick-driven BCD stopwatch (M:SS.d, 0:00.0 .. 9:59.9), directly downstream of the tick generator.
//   Consumes its single-cycle tick pulse, prescales it to 0.1 s steps and runs a start/pause/clear
//   state machine. BCD digits feed the seven-segment display multiplexer.
// PARAMETERS
//   TICKS_PER_STEP  10  input ticks per 0.1 s increment; legal range >= 1
//   WRAP            0   0 = saturate at 9:59.9 and stop; 1 = roll over to 0:00.0 and pulse wrap_pulse
// PORTS
//   clock       in   1  system clock; single clock domain
//   reset_n     in   1  asynchronous, active-low reset
//   tick_in     in   1  one-cycle pulse from the tick generator
//   btn_start   in   1  debounced, synchronous start/pause button level
//   clear       in   1  synchronous clear level
//   digit_ds    out  4  tenths of a second, BCD 0-9
//   digit_s0    out  4  seconds units, BCD 0-9
//   digit_s1    out  4  seconds tens, BCD 0-5
//   digit_m     out  4  minutes, BCD 0-9
//   running     out  1  1 while in RUN
//   at_max      out  1  1 while in HALT (WRAP=0 only)
//   wrap_pulse  out  1  one-cycle pulse on rollover 9:59.9 -> 0:00.0 (WRAP=1 only)
// BEHAVIOUR
//   Reset (reset_n=0, async): all digits 0, prescaler 0, state IDLE, running/at_max/wrap_pulse 0,
//     btn_prev 1 (a button held through reset release produces no start edge).
//   Start edge: start_evt = btn_start & ~btn_prev; btn_prev <= btn_start every cycle.
//   Prescaler: $clog2(TICKS_PER_STEP) bits, min 1; increments only in RUN on tick_in;
//     on tick_in at TICKS_PER_STEP-1 it returns to 0 and issues step (same cycle).
//   Step: BCD ripple increment ds->s0->s1->m; ds 9->0 carries, s0 9->0 carries, s1 5->0 carries;
//     registered, so digits change 1 clock after the completing tick_in.
//   States (registered): IDLE, RUN, PAUSE, HALT.
//     IDLE : start_evt -> RUN.
//     RUN  : start_evt -> PAUSE; step at 9:59.9 -> HALT (WRAP=0, digits hold 9:59.9)
//            or 0:00.0 + wrap_pulse=1 for one cycle, stay RUN (WRAP=1).
//     PAUSE: start_evt -> RUN; digits and prescaler hold (resume keeps partial count).
//     HALT : start_evt ignored; only clear or reset leave it.
//   clear=1 (any state): next cycle digits 0, prescaler 0, state IDLE, wrap_pulse 0;
//     clear overrides start_evt and tick_in in the same cycle; held clear keeps IDLE.
//   Simultaneous start_evt + completing tick_in in RUN: step is applied (state before the edge
//     governs), then state -> PAUSE.
//   tick_in while in IDLE/PAUSE/HALT: ignored, prescaler unchanged.
//   Outputs are pure register outputs or decodes of the state register; no combinational
//     path from inputs to outputs.
// TESTING (TICKS_PER_STEP=2 unless stated)
//   1 Reset release with btn_start held high -> stays IDLE, digits 0:00.0, running=0.
//   2 Start edge, then 20 tick_in pulses -> digits 0:01.0 one clock after the 20th tick; running=1.
//   3 Run 3 ticks, pause, 5 ticks, resume, 1 tick -> 0:00.2 (partial prescale kept, paused ticks ignored).
//   4 Preload by running to 9:59.8 then 4 ticks: WRAP=0 -> holds 9:59.9, at_max=1, start ignored;
//     WRAP=1 -> 0:00.0 with wrap_pulse high exactly one cycle, running stays 1.
//   5 clear asserted together with start edge and completing tick in RUN -> 0:00.0, IDLE, no step.
//   6 reset_n pulsed low mid-count between clock edges -> outputs zero immediately, before next edge.

Source files
------------

// File: rtl/stopwatch_core.sv
// Tick-driven BCD stopwatch (M:SS.d). Prescales the tick generator's pulse to 0.1 s
// steps and runs a start/pause/clear state machine feeding the display digits.
module stopwatch_core #(
  parameter int TICKS_PER_STEP = 10,
  parameter bit WRAP           = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       btn_start,
  input  logic       clear,
  output logic [3:0] digit_ds,
  output logic [3:0] digit_s0,
  output logic [3:0] digit_s1,
  output logic [3:0] digit_m,
  output logic       running,
  output logic       at_max,
  output logic       wrap_pulse
);

  localparam int PW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_STEP - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, HALT} state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc;
  logic          btn_prev;
  logic          start_evt;
  logic          step;
  logic          at_top;

  assign start_evt = btn_start & ~btn_prev;
  assign step      = (state == RUN) && tick_in && (presc == PRE_LAST);
  assign at_top    = (digit_m == 4'd9) && (digit_s1 == 4'd5) &&
                     (digit_s0 == 4'd9) && (digit_ds == 4'd9);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (start_evt) state_next = RUN;
        RUN: begin
          // Saturation wins over a simultaneous pause: the display is frozen either way.
          if (step && at_top && !WRAP) state_next = HALT;
          else if (start_evt)          state_next = PAUSE;
        end
        PAUSE: if (start_evt) state_next = RUN;
        HALT:  state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  // Button history is captured even during clear so a held button never fakes an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) btn_prev <= 1'b1;
    else          btn_prev <= btn_start;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc      <= '0;
      digit_ds   <= '0;
      digit_s0   <= '0;
      digit_s1   <= '0;
      digit_m    <= '0;
      wrap_pulse <= 1'b0;
    end else if (clear) begin
      presc      <= '0;
      digit_ds   <= '0;
      digit_s0   <= '0;
      digit_s1   <= '0;
      digit_m    <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (state == RUN && tick_in) begin
        if (presc == PRE_LAST) presc <= '0;
        else                   presc <= presc + 1'b1;
      end
      if (step) begin
        if (at_top) begin
          if (WRAP) begin
            digit_ds   <= '0;
            digit_s0   <= '0;
            digit_s1   <= '0;
            digit_m    <= '0;
            wrap_pulse <= 1'b1;
          end
        end else if (digit_ds != 4'd9) begin
          digit_ds <= digit_ds + 4'd1;
        end else begin
          digit_ds <= '0;
          if (digit_s0 != 4'd9) begin
            digit_s0 <= digit_s0 + 4'd1;
          end else begin
            digit_s0 <= '0;
            if (digit_s1 != 4'd5) begin
              digit_s1 <= digit_s1 + 4'd1;
            end else begin
              digit_s1 <= '0;
              digit_m  <= digit_m + 4'd1;
            end
          end
        end
      end
    end
  end

  assign running = (state == RUN);
  assign at_max  = (state == HALT);

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: a saturating and a wrapping instance share stimulus,
// both with TICKS_PER_STEP=2; expected digits are hand-computed BCD as {m,s1,s0,ds}.
module tb_stopwatch_core;

  logic clock = 1'b0;
  logic reset_n, tick_in, btn_start, clear;

  logic [3:0] sat_ds, sat_s0, sat_s1, sat_m;
  logic       sat_running, sat_at_max, sat_wrap;
  logic [3:0] wr_ds, wr_s0, wr_s1, wr_m;
  logic       wr_running, wr_at_max, wr_wrap;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  stopwatch_core #(.TICKS_PER_STEP(2), .WRAP(1'b0)) u_sat (
    .clock(clock), .reset_n(reset_n), .tick_in(tick_in), .btn_start(btn_start), .clear(clear),
    .digit_ds(sat_ds), .digit_s0(sat_s0), .digit_s1(sat_s1), .digit_m(sat_m),
    .running(sat_running), .at_max(sat_at_max), .wrap_pulse(sat_wrap)
  );

  stopwatch_core #(.TICKS_PER_STEP(2), .WRAP(1'b1)) u_wrap (
    .clock(clock), .reset_n(reset_n), .tick_in(tick_in), .btn_start(btn_start), .clear(clear),
    .digit_ds(wr_ds), .digit_s0(wr_s0), .digit_s1(wr_s1), .digit_m(wr_m),
    .running(wr_running), .at_max(wr_at_max), .wrap_pulse(wr_wrap)
  );

  wire [15:0] sat_digits = {sat_m, sat_s1, sat_s0, sat_ds};
  wire [15:0] wr_digits  = {wr_m, wr_s1, wr_s0, wr_ds};

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      $display("FAIL %s: observed %h expected %h", tag, observed, expected);
      $error("check %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      cycle();
      tick_in = 1'b0;
      cycle();
    end
  endtask

  task automatic press();
    btn_start = 1'b1;
    cycle();
    btn_start = 1'b0;
    cycle();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    tick_in   = 1'b0;
    btn_start = 1'b1;
    clear     = 1'b0;
    repeat (2) cycle();

    // 1: release reset with the button held -> no start edge
    reset_n = 1'b1;
    repeat (3) cycle();
    check("t1_digits", sat_digits, 16'h0000);
    check("t1_running", {15'd0, sat_running}, 16'd1 - 16'd1);

    // 2: start, then 20 ticks -> 0:01.0
    btn_start = 1'b0;
    cycle();
    press();
    check("t2_running", {15'd0, sat_running}, 16'd1);
    tick(19);
    check("t2_19ticks", sat_digits, 16'h0009);
    tick(1);
    check("t2_20ticks", sat_digits, 16'h0010);

    // 3: partial prescale kept across pause, paused ticks ignored
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    check("t3_clear_digits", sat_digits, 16'h0000);
    check("t3_clear_idle", {15'd0, sat_running}, 16'd0);
    press();
    tick(3);
    check("t3_run3", sat_digits, 16'h0001);
    press();
    check("t3_paused", {15'd0, sat_running}, 16'd0);
    tick(5);
    check("t3_paused_hold", sat_digits, 16'h0001);
    press();
    tick(1);
    check("t3_resume", sat_digits, 16'h0002);

    // 5: clear beats a simultaneous start edge and completing tick
    tick(1);
    btn_start = 1'b1;
    clear     = 1'b1;
    tick_in   = 1'b1;
    cycle();
    clear   = 1'b0;
    tick_in = 1'b0;
    check("t5_digits", sat_digits, 16'h0000);
    check("t5_idle", {15'd0, sat_running}, 16'd0);
    tick(2);
    check("t5_idle_ticks", sat_digits, 16'h0000);
    check("t5_no_edge", {15'd0, sat_running}, 16'd0);
    btn_start = 1'b0;
    cycle();

    // 4: run to 9:59.8 (5998 steps) with tick held every cycle
    press();
    tick_in = 1'b1;
    repeat (11996) cycle();
    tick_in = 1'b0;
    cycle();
    check("t4_sat_preload", sat_digits, 16'h9598);
    check("t4_wr_preload", wr_digits, 16'h9598);
    tick(2);
    check("t4_sat_top", sat_digits, 16'h9599);
    check("t4_sat_run_top", {15'd0, sat_running}, 16'd1);
    tick(1);
    tick_in = 1'b1;
    cycle();
    tick_in = 1'b0;
    check("t4_sat_hold", sat_digits, 16'h9599);
    check("t4_sat_at_max", {15'd0, sat_at_max}, 16'd1);
    check("t4_sat_stopped", {15'd0, sat_running}, 16'd0);
    check("t4_sat_no_wrap", {15'd0, sat_wrap}, 16'd0);
    check("t4_wr_rolled", wr_digits, 16'h0000);
    check("t4_wr_pulse", {15'd0, wr_wrap}, 16'd1);
    check("t4_wr_running", {15'd0, wr_running}, 16'd1);
    check("t4_wr_no_max", {15'd0, wr_at_max}, 16'd0);
    cycle();
    check("t4_wr_pulse_end", {15'd0, wr_wrap}, 16'd0);
    press();
    tick(2);
    check("t4_sat_start_ignored", {15'd0, sat_running}, 16'd0);
    check("t4_sat_still_max", {15'd0, sat_at_max}, 16'd1);
    check("t4_sat_still_hold", sat_digits, 16'h9599);

    // 6: asynchronous reset between edges
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_sat_digits", sat_digits, 16'h0000);
    check("t6_sat_at_max", {15'd0, sat_at_max}, 16'd0);
    check("t6_wr_digits", wr_digits, 16'h0000);
    check("t6_wr_running", {15'd0, wr_running}, 16'd0);
    cycle();
    reset_n = 1'b1;
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
